// File: rtl/spi_peripheral_if.sv
// SPI pin bundle between the external controller and the PWM configuration target.
interface spi_peripheral_if;
    logic sclk;
    logic copi;
    logic ncs;
    logic cipo;

    modport master (output sclk, output copi, output ncs, input cipo);
    modport slave  (input sclk, input copi, input ncs, output cipo);
endinterface

// File: rtl/spi_peripheral.sv
// SPI mode-0 target holding the nine-entry PWM configuration register file.
// Optional readback on cipo is enabled with the SPI_READBACK_EN macro.
module spi_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    spi_peripheral_if.slave  spi,
    output logic [7:0]       reg_en_out,
    output logic [7:0]       reg_en_pwm_out,
    output logic [7:0]       reg_out_3_0_pwm_gen_channel,
    output logic [7:0]       reg_out_7_4_pwm_gen_channel,
    output logic [7:0]       reg_pwm_gen_0_ch_0_duty_cycle,
    output logic [7:0]       reg_pwm_gen_0_ch_1_duty_cycle,
    output logic [7:0]       reg_pwm_gen_1_ch_0_duty_cycle,
    output logic [7:0]       reg_pwm_gen_1_ch_1_duty_cycle,
    output logic [7:0]       reg_pwm_gen_1_0_frequency_divider,
    output logic             wr_strobe
);
    localparam int NUM_REGS = 9;
    localparam int SETTLE   = SYNC_STAGES + 1;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] copi_sync_reg;
    logic [SYNC_STAGES-1:0] ncs_sync_reg;
    logic                   sclk_prev_reg;
    logic                   ncs_prev_reg;
    logic [2:0]             settle_reg;

    state_t                 state_reg;
    logic [4:0]             count_reg;
    logic [15:0]            shift_reg;
    logic                   overflow_reg;
    logic                   wr_strobe_reg;
    logic [7:0]             regs_reg [NUM_REGS];

    logic sclk_s, copi_s, ncs_s, settled;
    logic sclk_rise, ncs_rise, ncs_fall;
    logic [15:0] shift_next;
    logic commit_ok;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sclk_sync_reg[gi] <= 1'b0;
                        copi_sync_reg[gi] <= 1'b0;
                        ncs_sync_reg[gi]  <= 1'b1;
                    end else begin
                        sclk_sync_reg[gi] <= spi.sclk;
                        copi_sync_reg[gi] <= spi.copi;
                        ncs_sync_reg[gi]  <= spi.ncs;
                    end
                end
            end else begin : g_next
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        sclk_sync_reg[gi] <= 1'b0;
                        copi_sync_reg[gi] <= 1'b0;
                        ncs_sync_reg[gi]  <= 1'b1;
                    end else begin
                        sclk_sync_reg[gi] <= sclk_sync_reg[gi-1];
                        copi_sync_reg[gi] <= copi_sync_reg[gi-1];
                        ncs_sync_reg[gi]  <= ncs_sync_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign copi_s = copi_sync_reg[SYNC_STAGES-1];
    assign ncs_s  = ncs_sync_reg[SYNC_STAGES-1];

    // Edges are ignored until the reset values have drained out of the chains,
    // so an ncs already low at reset release does not look like a frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_prev_reg <= 1'b0;
            ncs_prev_reg  <= 1'b1;
            settle_reg    <= 3'd0;
        end else begin
            sclk_prev_reg <= sclk_s;
            ncs_prev_reg  <= ncs_s;
            if (settle_reg != 3'(SETTLE))
                settle_reg <= settle_reg + 3'd1;
        end
    end

    assign settled    = (settle_reg == 3'(SETTLE));
    assign sclk_rise  = settled &  sclk_s & ~sclk_prev_reg;
    assign ncs_rise   = settled &  ncs_s  & ~ncs_prev_reg;
    assign ncs_fall   = settled & ~ncs_s  &  ncs_prev_reg;
    assign shift_next = {shift_reg[14:0], copi_s};

    function automatic logic addr_ok(input logic [6:0] addr);
        return (int'(addr) <= MAX_ADDR) && (int'(addr) < NUM_REGS);
    endfunction

    assign commit_ok = (count_reg == 5'd16) && !overflow_reg && shift_reg[15]
                       && addr_ok(shift_reg[14:8]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            count_reg     <= 5'd0;
            shift_reg     <= 16'd0;
            overflow_reg  <= 1'b0;
            wr_strobe_reg <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                regs_reg[i] <= 8'h00;
        end else begin
            wr_strobe_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ncs_fall) begin
                        count_reg    <= 5'd0;
                        shift_reg    <= 16'd0;
                        overflow_reg <= 1'b0;
                        state_reg    <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Frame end takes priority over a coincident sclk edge.
                    if (ncs_rise) begin
                        state_reg <= COMMIT;
                    end else if (sclk_rise) begin
                        if (count_reg == 5'd16) begin
                            overflow_reg <= 1'b1;
                        end else begin
                            shift_reg <= shift_next;
                            count_reg <= count_reg + 5'd1;
                        end
                    end
                end
                COMMIT: begin
                    if (commit_ok) begin
                        regs_reg[shift_reg[11:8]] <= shift_reg[7:0];
                        wr_strobe_reg             <= 1'b1;
                    end
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic [7:0] tx_reg;
    logic       cipo_reg;

    assign sclk_fall = settled & ~sclk_s & sclk_prev_reg;

    // Snapshot on the eighth received bit of a read; shift out on sclk falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_reg   <= 8'h00;
            cipo_reg <= 1'b0;
        end else if (state_reg != SHIFT || ncs_rise) begin
            tx_reg   <= 8'h00;
            cipo_reg <= 1'b0;
        end else if (sclk_rise && count_reg == 5'd7 && !shift_next[7]) begin
            tx_reg <= addr_ok(shift_next[6:0]) ? regs_reg[shift_next[3:0]] : 8'h00;
        end else if (sclk_fall) begin
            cipo_reg <= tx_reg[7];
            tx_reg   <= {tx_reg[6:0], 1'b0};
        end
    end

    assign spi.cipo = cipo_reg;
`else
    assign spi.cipo = 1'b0;
`endif

    assign reg_en_out                        = regs_reg[0];
    assign reg_en_pwm_out                    = regs_reg[1];
    assign reg_out_3_0_pwm_gen_channel       = regs_reg[2];
    assign reg_out_7_4_pwm_gen_channel       = regs_reg[3];
    assign reg_pwm_gen_0_ch_0_duty_cycle     = regs_reg[4];
    assign reg_pwm_gen_0_ch_1_duty_cycle     = regs_reg[5];
    assign reg_pwm_gen_1_ch_0_duty_cycle     = regs_reg[6];
    assign reg_pwm_gen_1_ch_1_duty_cycle     = regs_reg[7];
    assign reg_pwm_gen_1_0_frequency_divider = regs_reg[8];
    assign wr_strobe                         = wr_strobe_reg;
endmodule

// File: tb/tb_spi_peripheral.sv
// Directed-frame bench for spi_peripheral with a frame-level register-file model
// checked every cycle; readback checks are active when SPI_READBACK_EN is defined.
module tb_spi_peripheral;
    localparam int SYNC_STAGES = 2;
    localparam int MAX_ADDR    = 8;
    localparam int HALF        = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    spi_peripheral_if spi ();

    logic [7:0] r0, r1, r2, r3, r4, r5, r6, r7, r8;
    logic       wr_strobe;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0]  exp_regs [9];
    logic        exp_strobe = 1'b0;
    int          strobes_seen = 0;
    bit          in_gap = 1'b1;
    logic [31:0] last_rx = 32'd0;

    spi_peripheral #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(MAX_ADDR)) dut (
        .clk                               (clk),
        .rst_n                             (rst_n),
        .spi                               (spi),
        .reg_en_out                        (r0),
        .reg_en_pwm_out                    (r1),
        .reg_out_3_0_pwm_gen_channel       (r2),
        .reg_out_7_4_pwm_gen_channel       (r3),
        .reg_pwm_gen_0_ch_0_duty_cycle     (r4),
        .reg_pwm_gen_0_ch_1_duty_cycle     (r5),
        .reg_pwm_gen_1_ch_0_duty_cycle     (r6),
        .reg_pwm_gen_1_ch_1_duty_cycle     (r7),
        .reg_pwm_gen_1_0_frequency_divider (r8),
        .wr_strobe                         (wr_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("reg0", 32'(r0), 32'(exp_regs[0]));
            check("reg1", 32'(r1), 32'(exp_regs[1]));
            check("reg2", 32'(r2), 32'(exp_regs[2]));
            check("reg3", 32'(r3), 32'(exp_regs[3]));
            check("reg4", 32'(r4), 32'(exp_regs[4]));
            check("reg5", 32'(r5), 32'(exp_regs[5]));
            check("reg6", 32'(r6), 32'(exp_regs[6]));
            check("reg7", 32'(r7), 32'(exp_regs[7]));
            check("reg8", 32'(r8), 32'(exp_regs[8]));
            check("wr_strobe", 32'(wr_strobe), 32'(exp_strobe));
            if (wr_strobe === 1'b1) strobes_seen++;
`ifdef SPI_READBACK_EN
            if (in_gap) check("cipo_idle", 32'(spi.cipo), 32'd0);
`else
            check("cipo_tied", 32'(spi.cipo), 32'd0);
`endif
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic begin_frame();
        @(negedge clk);
        in_gap   = 1'b0;
        spi.ncs  = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // Clocks bits[hi] down to bits[lo]; cipo is sampled just before each rise.
    task automatic clock_bits(input logic [31:0] bits, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            spi.sclk = 1'b0;
            spi.copi = bits[i];
            repeat (HALF) @(negedge clk);
            last_rx  = {last_rx[30:0], spi.cipo};
            spi.sclk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
    endtask

    // Raises ncs and advances the model at the point the write must be visible.
    task automatic end_frame(input logic [31:0] bits, input int nbits);
        int  addr;
        bit  valid;
        spi.sclk = 1'b0;
        repeat (HALF) @(negedge clk);
        spi.ncs = 1'b1;
        addr  = int'(bits[14:8]);
        valid = (nbits == 16) && bits[15] && (addr <= MAX_ADDR);
        repeat (SYNC_STAGES + 2) @(posedge clk);
        if (valid) begin
            exp_regs[addr] = bits[7:0];
            exp_strobe     = 1'b1;
        end
        @(posedge clk);
        exp_strobe = 1'b0;
        repeat (HALF) @(negedge clk);
        in_gap = 1'b1;
        $display("[TB] frame 0x%0h bits=%0d -> %s", bits, nbits, valid ? "write" : "discard");
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits);
        last_rx = 32'd0;
        begin_frame();
        clock_bits(bits, nbits - 1, 0);
        end_frame(bits, nbits);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
        spi.ncs  = 1'b1;
        spi.sclk = 1'b0;
        spi.copi = 1'b0;
        rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_reg0", 32'(r0), 32'h00);
        check("rst_reg8", 32'(r8), 32'h00);
        check("rst_strobe", 32'(wr_strobe), 32'd0);
        check("rst_cipo", 32'(spi.cipo), 32'd0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        send_frame(32'h80FF, 16);
        check("lit_en_out", 32'(r0), 32'hFF);
        check("lit_strobes_1", 32'(strobes_seen), 32'd1);

        send_frame(32'h8480, 16);
        send_frame(32'h8810, 16);
        check("lit_duty_0_0", 32'(r4), 32'h80);
        check("lit_freq_div", 32'(r8), 32'h10);
        check("lit_en_out_kept", 32'(r0), 32'hFF);

        send_frame(32'hFF55, 16);
        send_frame(32'h0955, 16);
        check("lit_strobes_3", 32'(strobes_seen), 32'd3);

        send_frame(32'h40BB, 15);
        send_frame(32'h102EE, 17);
        check("lit_strobes_short_long", 32'(strobes_seen), 32'd3);
        send_frame(32'h8133, 16);
        check("lit_en_pwm", 32'(r1), 32'h33);

        // Reset in the middle of a frame, with ncs still low at release.
        begin_frame();
        clock_bits(32'h82AA, 15, 7);
        rst_n = 1'b0;
        for (int i = 0; i < 9; i++) exp_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        check("lit_rst_reg2", 32'(r2), 32'h00);
        check("lit_rst_reg0", 32'(r0), 32'h00);
        rst_n = 1'b1;
        clock_bits(32'h82AA, 6, 0);
        end_frame(32'h82AA, 7);
        check("lit_after_rst_reg2", 32'(r2), 32'h00);
        send_frame(32'h82AA, 16);
        check("lit_clean_reg2", 32'(r2), 32'hAA);

        send_frame(32'h86C3, 16);
        send_frame(32'h0600, 16);
        check("lit_reg6", 32'(r6), 32'hC3);
`ifdef SPI_READBACK_EN
        check("readback_data", 32'(last_rx[7:0]), 32'hC3);
`else
        check("readback_absent", 32'(last_rx[7:0]), 32'h00);
`endif
        check("lit_strobes_total", 32'(strobes_seen), 32'd6);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/spi_peripheral.md
Name: spi_peripheral

Overview:
SPI target (mode 0) that receives register writes from an external controller and holds the PWM configuration register file. Its registered outputs drive the PWM block's configuration inputs directly. SPI pins are asynchronous to clk and are oversampled through synchronizers. All state lives in the clk domain.

Parameters:
SYNC_STAGES, 2, flip-flop depth of the synchronizer on sclk, copi and ncs (legal range 2..4)
MAX_ADDR, 8, highest writable register address; writes above it are discarded

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
sclk  input  1  SPI clock from controller, async to clk
copi  input  1  SPI controller-out/target-in data, async
ncs  input  1  SPI chip select, active-low, async
cipo  output  1  SPI target-out data (see Optional Feature)
reg_en_out  output  8  addr 0x00
reg_en_pwm_out  output  8  addr 0x01
reg_out_3_0_pwm_gen_channel  output  8  addr 0x02
reg_out_7_4_pwm_gen_channel  output  8  addr 0x03
reg_pwm_gen_0_ch_0_duty_cycle  output  8  addr 0x04
reg_pwm_gen_0_ch_1_duty_cycle  output  8  addr 0x05
reg_pwm_gen_1_ch_0_duty_cycle  output  8  addr 0x06
reg_pwm_gen_1_ch_1_duty_cycle  output  8  addr 0x07
reg_pwm_gen_1_0_frequency_divider  output  8  addr 0x08
wr_strobe  output  1  one-clk pulse when a write commits

Behaviour:
- Reset is asynchronous (rst_n low), clock is clk.
- Reset values: all nine registers 0x00, wr_strobe 0, cipo 0, FSM IDLE, bit counter 0, shift register 0. The synchronizer flops reset to ncs=1, sclk=0, copi=0.
- Frame format: exactly 16 bits, MSB first.
  - bit15: R/W (1 = write, 0 = read).
  - bits14:8: address (7 bits).
  - bits7:0: data.
- copi is sampled on sclk rising edges. The sclk rising edge is detected in the clk domain as the synchronized sclk going from 0 to 1 between consecutive clk cycles.
- Supported SCLK frequency is at most clk/8. Faster SCLK is unsupported and unverified.
- FSM states:
  - IDLE: waits for a synchronized ncs falling edge, then clears the counter, shift register and overflow flag and goes to SHIFT. Other sclk/copi activity is ignored.
  - SHIFT: on each detected sclk rise, if count < 16, shift copi into the LSB and increment count. If count == 16, set overflow and do not shift. On a synchronized ncs rising edge, go to COMMIT.
  - COMMIT (one cycle): commit only if count == 16, overflow == 0, R/W == 1 and address <= MAX_ADDR. A commit loads the data into the addressed register and pulses wr_strobe. The FSM always returns to IDLE.
- Commit timing: the register update and wr_strobe are visible in the cycle after COMMIT. Total delay from the physical ncs rise is SYNC_STAGES+2 clk edges (4 at the default).
- Frames that are discarded with no register change and no wr_strobe:
  - short frames (< 16 bits);
  - long frames (> 16 bits);
  - reads;
  - out-of-range addresses.
- An ncs rise and an sclk rise detected in the same cycle: the ncs rise wins and that sclk edge is not counted.
- ncs pulse high for a single clk cycle: ignored if the synchronizer filters it; otherwise treated as a frame end.
- Reset asserted mid-frame: immediate return to reset values. The partial frame is lost. The next frame needs a fresh ncs falling edge after reset release; if ncs is already low at release, nothing is received until ncs goes high then low.
- Registers hold their value indefinitely between writes. There is no auto-clear.

Optional Feature:
- Macro: SPI_READBACK_EN.
- Defined:
  - For a frame with R/W = 0, once 8 bits are received and address <= MAX_ADDR, the addressed register is snapshotted into an output shift register.
  - On each subsequent synchronized sclk falling edge, cipo presents the next bit, MSB first. The controller samples on the following sclk rise.
  - For an invalid address, cipo outputs 0x00.
  - cipo is 0 whenever ncs is high.
  - Reads never modify registers and never pulse wr_strobe.
- Undefined: cipo is tied to 0 and read frames are silently discarded.

Test Plan:
- Reset, then frame 0x80FF (write addr 0x00 data 0xFF) at SCLK = clk/10 -> reg_en_out = 0xFF within 4 clk of ncs rise; one wr_strobe pulse; all other registers stay 0x00.
- Frames 0x8480 then 0x8810 -> reg_pwm_gen_0_ch_0_duty_cycle = 0x80, reg_pwm_gen_1_0_frequency_divider = 0x10; other registers unchanged.
- Frame 0xFF55 (addr 0x7F) and frame 0x0955 (read) -> no register change, no wr_strobe.
- 15-bit frame and 17-bit frame (each with valid-write content) -> no change; a following normal 0x8133 frame -> reg_en_pwm_out = 0x33.
- rst_n pulsed low after 9 bits of 0x82AA; ncs cycled; then 0x82AA sent -> register 0x02 is 0x00 after the reset and 0xAA after the clean frame.
- With SPI_READBACK_EN: write 0x86C3, then read frame 0x0600 -> cipo shifts out 1100_0011 on bits 7..0; cipo = 0 while ncs is high. Without the macro: cipo stays 0 throughout.
